// File: rtl/cpu_cycle_sequencer_pkg.sv
// Shared control-unit definitions for the cycle sequencer: FSM encoding,
// T-step one-hot constants and the decoder length clamp.
package cpu_cycle_sequencer_pkg;

  localparam int unsigned MAX_CYCLES_DEFAULT = 8;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  localparam logic [3:0] STEP_T1 = 4'b0001;
  localparam logic [3:0] STEP_T2 = 4'b0010;
  localparam logic [3:0] STEP_T3 = 4'b0100;
  localparam logic [3:0] STEP_T4 = 4'b1000;

  // Zero or over-long decoder lengths degrade to a single M-cycle.
  function automatic logic [3:0] clamp_cycle_length(input logic [3:0] len,
                                                    input int unsigned max_cycles);
    if ((len == 4'd0) || (32'(len) > max_cycles)) begin
      return 4'd1;
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/cpu_cycle_sequencer_cycle_step_ring.sv
// Four-phase one-hot T-step rotator; holds when not advancing, snaps to T1
// when forced or in reset.
module cycle_step_ring
  import cpu_cycle_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       advance,
  input  logic       force_t1,
  output logic [3:0] step
);

  logic [3:0] step_r;

  // Rotate T1->T2->T3->T4->T1 on each advancing clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_r <= STEP_T1;
    end else if (force_t1) begin
      step_r <= STEP_T1;
    end else if (advance) begin
      step_r <= {step_r[2:0], step_r[3]};
    end
  end

  assign step = step_r;

endmodule

// File: rtl/cpu_cycle_sequencer.sv
// Control-unit T-step / M-cycle sequencer: post-reset fetch, instruction
// length tracking, early exit, bus-wait stall and HALT/wake.
module cpu_cycle_sequencer
  import cpu_cycle_sequencer_pkg::*;
#(
  parameter int unsigned MAX_CYCLES = MAX_CYCLES_DEFAULT
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic                  i_Stall,
  input  logic [3:0]            i_Cycle_Length,
  input  logic                  i_Early_Exit,
  input  logic                  i_Halt_Req,
  input  logic                  i_Wake,
  output logic [3:0]            o_Cycle_Step,
  output logic [MAX_CYCLES-1:0] o_Cycle_Count,
  output logic                  o_Fetch_Cycle,
  output logic                  o_Last_Cycle,
  output logic                  o_Instr_Done,
  output logic                  o_Halted
);

  logic [1:0]            state_r;
  logic [MAX_CYCLES-1:0] count_r;
  logic [3:0]            len_r;
  logic                  exit_r;

  logic [3:0] step_s;
  logic [3:0] len_clamped_s;
  logic       len_hit_s;
  logic       last_s;
  logic       at_t4_s;
  logic       in_halt_s;
  logic       advance_s;

  assign in_halt_s     = (state_r == ST_HALT);
  assign advance_s     = !i_Stall && !in_halt_s;
  assign at_t4_s       = step_s[3];
  assign len_clamped_s = clamp_cycle_length(i_Cycle_Length, MAX_CYCLES);
  assign len_hit_s     = |(count_r & (MAX_CYCLES'(1) << (len_r - 4'd1)));

  cycle_step_ring u_step_ring (
    .clk      (i_Clk),
    .rst      (i_Reset),
    .advance  (advance_s),
    .force_t1 (in_halt_s),
    .step     (step_s)
  );

  // During the first M-cycle the latched length is not valid yet, so use the live decoder value.
  always_comb begin
    last_s = 1'b0;
    if (state_r == ST_RUN) begin
      if (count_r[0]) begin
        last_s = (len_clamped_s == 4'd1) || exit_r;
      end else begin
        last_s = len_hit_s || exit_r;
      end
    end else begin
      last_s = 1'b0;
    end
  end

  // FSM, M-cycle shifter, length latch and early-exit flag.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_r <= ST_FETCH;
      count_r <= '0;
      len_r   <= 4'd1;
      exit_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (!i_Stall && at_t4_s) begin
            state_r <= ST_RUN;
            count_r <= MAX_CYCLES'(1);
          end
        end
        ST_RUN: begin
          if (!i_Stall) begin
            if (count_r[0] && step_s[0]) begin
              len_r <= len_clamped_s;
            end
            if (at_t4_s) begin
              if (last_s) begin
                exit_r <= 1'b0;
                if (i_Halt_Req) begin
                  state_r <= ST_HALT;
                  count_r <= '0;
                end else begin
                  count_r <= MAX_CYCLES'(1);
                end
              end else begin
                count_r <= count_r << 1;
                if (i_Early_Exit) begin
                  exit_r <= 1'b1;
                end
              end
            end
          end
        end
        ST_HALT: begin
          if (i_Wake) begin
            state_r <= ST_RUN;
            count_r <= MAX_CYCLES'(1);
          end
        end
        default: begin
          state_r <= ST_FETCH;
          count_r <= '0;
        end
      endcase
    end
  end

  assign o_Cycle_Step  = step_s;
  assign o_Cycle_Count = count_r;
  assign o_Fetch_Cycle = (state_r == ST_FETCH);
  assign o_Halted      = in_halt_s;
  assign o_Last_Cycle  = last_s;
  assign o_Instr_Done  = (state_r == ST_RUN) && at_t4_s && last_s && !i_Stall;

endmodule

// File: tb/tb_cpu_cycle_sequencer.sv
// Self-checking bench for cpu_cycle_sequencer: directed scenarios plus a
// randomized run, all compared against an index-based behavioural model.
module tb_cpu_cycle_sequencer;

  localparam int MAXC = 8;
  localparam int M_FETCH = 0;
  localparam int M_RUN   = 1;
  localparam int M_HALT  = 2;
  localparam logic [15:0] RESET_VEC = 16'h1008;

  logic       i_Clk = 1'b0;
  logic       i_Reset = 1'b1;
  logic       i_Stall = 1'b0;
  logic [3:0] i_Cycle_Length = 4'd1;
  logic       i_Early_Exit = 1'b0;
  logic       i_Halt_Req = 1'b0;
  logic       i_Wake = 1'b0;
  logic [3:0] o_Cycle_Step;
  logic [MAXC-1:0] o_Cycle_Count;
  logic       o_Fetch_Cycle, o_Last_Cycle, o_Instr_Done, o_Halted;
  logic [15:0] dut_vec;

  int vectors = 0;
  int miscompares = 0;

  // Model: mode, T index (0..3), M-cycle index, latched length, exit flag.
  int md, mt, mm, mlen;
  bit mexit;

  cpu_cycle_sequencer #(.MAX_CYCLES(MAXC)) dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Stall(i_Stall),
    .i_Cycle_Length(i_Cycle_Length), .i_Early_Exit(i_Early_Exit),
    .i_Halt_Req(i_Halt_Req), .i_Wake(i_Wake),
    .o_Cycle_Step(o_Cycle_Step), .o_Cycle_Count(o_Cycle_Count),
    .o_Fetch_Cycle(o_Fetch_Cycle), .o_Last_Cycle(o_Last_Cycle),
    .o_Instr_Done(o_Instr_Done), .o_Halted(o_Halted)
  );

  assign dut_vec = {o_Cycle_Step, o_Cycle_Count, o_Fetch_Cycle, o_Last_Cycle, o_Instr_Done, o_Halted};

  always #5 i_Clk = ~i_Clk;

  function automatic int tb_clamp(input int v);
    return ((v == 0) || (v > MAXC)) ? 1 : v;
  endfunction

  function automatic bit exp_last();
    if (md != M_RUN) return 1'b0;
    if (mexit) return 1'b1;
    if (mm == 0) return tb_clamp(int'(i_Cycle_Length)) == 1;
    return mm == mlen - 1;
  endfunction

  function automatic logic [15:0] exp_vec();
    logic [3:0] s;
    logic [7:0] c;
    bit l;
    bit d;
    s = 4'b0001 << mt;
    c = (md == M_RUN) ? (8'b0000_0001 << mm) : 8'b0000_0000;
    l = exp_last();
    d = l && (mt == 3) && !i_Stall;
    return {s, c, (md == M_FETCH), l, d, (md == M_HALT)};
  endfunction

  task automatic model_reset();
    md = M_FETCH; mt = 0; mm = 0; mlen = 1; mexit = 1'b0;
  endtask

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic model_step();
    bit l;
    l = exp_last();
    if (i_Reset) begin
      model_reset();
    end else begin
      case (md)
        M_FETCH: if (!i_Stall) begin
          if (mt == 3) begin md = M_RUN; mm = 0; mt = 0; end
          else mt++;
        end
        M_RUN: if (!i_Stall) begin
          if (mm == 0 && mt == 0) mlen = tb_clamp(int'(i_Cycle_Length));
          if (mt == 3) begin
            mt = 0;
            if (l) begin
              mexit = 1'b0; mm = 0;
              if (i_Halt_Req) md = M_HALT;
            end else begin
              if (i_Early_Exit) mexit = 1'b1;
              mm++;
            end
          end else begin
            mt++;
          end
        end
        M_HALT: if (i_Wake) begin md = M_RUN; mm = 0; mt = 0; end
        default: model_reset();
      endcase
    end
  endtask

  task automatic advance();
    model_step();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic apply_reset(input logic [3:0] len);
    i_Stall = 1'b0; i_Early_Exit = 1'b0; i_Halt_Req = 1'b0; i_Wake = 1'b0;
    i_Cycle_Length = len;
    i_Reset = 1'b1;
    model_reset();
    @(posedge i_Clk);
    #1;
    i_Reset = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    @(negedge i_Clk);
    vectors++;
    if (dut_vec !== RESET_VEC) begin
      miscompares++;
      $display("FAIL reset_state: got %h expected %h", dut_vec, RESET_VEC);
    end
    vectors++;
    if (dut_vec !== exp_vec()) begin
      miscompares++;
      $display("FAIL reset_model: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_len2();
    int done_clk;
    done_clk = -1;
    apply_reset(4'd2);
    for (int k = 1; k <= 16; k++) begin
      @(negedge i_Clk);
      vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL len2 clk %0d: got %h expected %h", k, dut_vec, exp_vec());
      end
      if (o_Instr_Done === 1'b1 && done_clk < 0) done_clk = k;
      advance();
    end
    vectors++;
    if (done_clk !== 12) begin
      miscompares++;
      $display("FAIL len2_done_clock: got %0d expected 12", done_clk);
    end
  endtask

  task automatic test_back_to_back();
    int dones;
    dones = 0;
    apply_reset(4'd1);
    for (int k = 1; k <= 16; k++) begin
      @(negedge i_Clk);
      vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL b2b clk %0d: got %h expected %h", k, dut_vec, exp_vec());
      end
      if (k > 4) begin
        vectors++;
        if (o_Last_Cycle !== 1'b1 || o_Cycle_Count !== 8'h01) begin
          miscompares++;
          $display("FAIL b2b_last clk %0d: got last %b count %h expected 1 01", k, o_Last_Cycle, o_Cycle_Count);
        end
      end
      if (o_Instr_Done === 1'b1) dones++;
      advance();
    end
    vectors++;
    if (dones !== 3) begin
      miscompares++;
      $display("FAIL b2b_done_count: got %0d expected 3", dones);
    end
  endtask

  task automatic test_early_exit();
    int done_clk;
    done_clk = -1;
    apply_reset(4'd5);
    for (int k = 1; k <= 40 && done_clk < 0; k++) begin
      i_Early_Exit = (md == M_RUN && mm == 1 && mt == 3);
      @(negedge i_Clk);
      vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL early_exit clk %0d: got %h expected %h", k, dut_vec, exp_vec());
      end
      if (o_Instr_Done === 1'b1) done_clk = k;
      advance();
    end
    i_Early_Exit = 1'b0;
    vectors++;
    if (done_clk - 4 !== 12) begin
      miscompares++;
      $display("FAIL early_exit_run_clocks: got %0d expected 12", done_clk - 4);
    end
    @(negedge i_Clk);
    vectors++;
    if (o_Cycle_Count !== 8'h01 || o_Last_Cycle !== 1'b0) begin
      miscompares++;
      $display("FAIL early_exit_next: got count %h last %b expected 01 0", o_Cycle_Count, o_Last_Cycle);
    end
    advance();
  endtask

  task automatic test_stall();
    int done_clk;
    int stall_left;
    bit stalled_once;
    done_clk = -1; stall_left = 0; stalled_once = 1'b0;
    apply_reset(4'd4);
    for (int k = 1; k <= 60 && done_clk < 0; k++) begin
      if (!stalled_once && md == M_RUN && mm == 1 && mt == 1) begin
        stall_left = 3; stalled_once = 1'b1;
      end
      i_Stall = (stall_left > 0);
      @(negedge i_Clk);
      vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL stall clk %0d: got %h expected %h", k, dut_vec, exp_vec());
      end
      if (i_Stall && (o_Instr_Done !== 1'b0 || o_Cycle_Step !== 4'b0010 || o_Cycle_Count !== 8'h02)) begin
        miscompares++;
        $display("FAIL stall_frozen clk %0d: got step %b count %h done %b expected 0010 02 0", k, o_Cycle_Step, o_Cycle_Count, o_Instr_Done);
      end
      if (o_Instr_Done === 1'b1) done_clk = k;
      advance();
      if (stall_left > 0) stall_left--;
    end
    i_Stall = 1'b0;
    vectors++;
    if (done_clk !== 4 + 16 + 3) begin
      miscompares++;
      $display("FAIL stall_done_clock: got %0d expected 23", done_clk);
    end
  endtask

  task automatic test_halt_wake();
    int done_clk;
    done_clk = -1;
    apply_reset(4'd2);
    i_Halt_Req = 1'b1;
    for (int k = 1; k <= 30 && done_clk < 0; k++) begin
      @(negedge i_Clk);
      vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL halt_entry clk %0d: got %h expected %h", k, dut_vec, exp_vec());
      end
      if (o_Instr_Done === 1'b1) done_clk = k;
      advance();
    end
    i_Halt_Req = 1'b0;
    vectors++;
    if (done_clk !== 12) begin
      miscompares++;
      $display("FAIL halt_done_clock: got %0d expected 12", done_clk);
    end
    for (int k = 0; k < 10; k++) begin
      i_Stall = k[0];
      @(negedge i_Clk);
      vectors++;
      if (o_Halted !== 1'b1 || o_Cycle_Count !== 8'h00 || o_Cycle_Step !== 4'b0001 || dut_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL halted clk %0d: got %h expected %h", k, dut_vec, exp_vec());
      end
      advance();
    end
    i_Stall = 1'b1;
    i_Wake = 1'b1;
    @(negedge i_Clk);
    advance();
    i_Wake = 1'b0;
    i_Stall = 1'b0;
    @(negedge i_Clk);
    vectors++;
    if (o_Halted !== 1'b0 || o_Cycle_Count !== 8'h01 || o_Cycle_Step !== 4'b0001 || dut_vec !== exp_vec()) begin
      miscompares++;
      $display("FAIL wake: got %h expected %h", dut_vec, exp_vec());
    end
    advance();
  endtask

  task automatic test_reset_mid();
    bit reached;
    reached = 1'b0;
    apply_reset(4'd6);
    for (int k = 1; k <= 40 && !reached; k++) begin
      if (md == M_RUN && mm == 3 && mt == 2) begin
        reached = 1'b1;
      end else begin
        @(negedge i_Clk);
        vectors++;
        if (dut_vec !== exp_vec()) begin
          miscompares++;
          $display("FAIL reset_mid_run clk %0d: got %h expected %h", k, dut_vec, exp_vec());
        end
        advance();
      end
    end
    vectors++;
    if (!reached || o_Cycle_Step !== 4'b0100 || o_Cycle_Count !== 8'h08) begin
      miscompares++;
      $display("FAIL reset_mid_position: got step %b count %h expected 0100 08", o_Cycle_Step, o_Cycle_Count);
    end
    i_Reset = 1'b1;
    model_reset();
    @(negedge i_Clk);
    vectors++;
    if (dut_vec !== RESET_VEC) begin
      miscompares++;
      $display("FAIL reset_mid_state: got %h expected %h", dut_vec, RESET_VEC);
    end
    advance();
    i_Reset = 1'b0;
  endtask

  task automatic test_random();
    apply_reset(4'(1 + $urandom_range(0, 7)));
    for (int k = 0; k < 3000; k++) begin
      i_Reset      = ($urandom_range(0, 299) == 0);
      i_Stall      = ($urandom_range(0, 4) == 0);
      i_Early_Exit = ($urandom_range(0, 5) == 0);
      i_Halt_Req   = ($urandom_range(0, 7) == 0);
      i_Wake       = ($urandom_range(0, 9) == 0);
      if (md != M_RUN || mm != 0) i_Cycle_Length = 4'($urandom_range(0, 15));
      if (i_Reset) model_reset();
      @(negedge i_Clk);
      vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL random cyc %0d: got %h expected %h", k, dut_vec, exp_vec());
      end
      advance();
    end
    i_Reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_len2();
    test_back_to_back();
    test_early_exit();
    test_stall();
    test_halt_wake();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_cycle_sequencer.md
# cpu_cycle_sequencer

Generates the one-hot T-step (`o_Cycle_Step`) and M-cycle (`o_Cycle_Count`) buses that drive every instruction microcode block in the control unit.
- Advances four T-steps per M-cycle.
- Ends each instruction after the decoder-supplied M-cycle count, or earlier on a failed condition.
- Overlaps the next opcode fetch with the last M-cycle.
- Handles the post-reset fetch, bus-wait stalls and HALT/wake.

## Interface
Parameters:
- `MAX_CYCLES`, default 8: width of `o_Cycle_Count`, i.e. the longest instruction in M-cycles.

Ports:
- `i_Clk` in 1: system clock, all state on rising edge.
- `i_Reset` in 1: asynchronous, active-high reset.
- `i_Stall` in 1: bus wait; freezes all sequencer state.
- `i_Cycle_Length` in 4: M-cycles of the current opcode, from the decoder. Valid during `o_Cycle_Count[0]`.
- `i_Early_Exit` in 1: condition failed; end the instruction after the current M-cycle.
- `i_Halt_Req` in 1: HALT executing; idle after this instruction.
- `i_Wake` in 1: interrupt pending; leave HALT.
- `o_Cycle_Step` out 4: one-hot T-step, T1 = bit 0.
- `o_Cycle_Count` out `MAX_CYCLES`: one-hot M-cycle index. All zero outside RUN.
- `o_Fetch_Cycle` out 1: the post-reset fetch M-cycle is in progress.
- `o_Last_Cycle` out 1: the current M-cycle is the instruction's last; microcode performs IR fetch here.
- `o_Instr_Done` out 1: single-clock strobe at T4 of the last M-cycle.
- `o_Halted` out 1: in HALT.

## Operation
- State machine: FETCH, RUN, HALT. Reset enters FETCH.
- **Step ring**
  - In FETCH and RUN, `o_Cycle_Step` rotates 0001→0010→0100→1000→0001 on each clock with `i_Stall` = 0.
  - In HALT it is held at 0001.
- **FETCH**
  - One M-cycle with `o_Cycle_Count` = 0 and `o_Fetch_Cycle` = 1.
  - At the T4 edge: go to RUN, count = bit 0.
- **Length latch**
  - `len_q` is loaded from `i_Cycle_Length` at the T1 edge of count[0].
  - Values 0 or >`MAX_CYCLES` are clamped to 1.
- **`o_Last_Cycle` (RUN only)**
  - During count[0]: clamp(`i_Cycle_Length`) == 1.
  - Otherwise: count bit `len_q`-1 is set.
  - In both cases, ORed with `exit_q`.
- **Early exit**
  - `exit_q` is set at the T4 edge when `i_Early_Exit` = 1 and the current cycle is not last. It makes the following M-cycle the last.
  - `exit_q` clears when the instruction completes.
- **Edge actions at T4 in RUN (not stalled)**
  - If not last: count shifts left one bit.
  - If last: `o_Instr_Done` = 1 during that clock.
  - If last and `i_Halt_Req` = 1: go to HALT, count = 0.
  - If last and `i_Halt_Req` = 0: count = bit 0 (next opcode already in IR).
- **HALT**
  - Outputs step 0001, count 0, `o_Halted` = 1.
  - A clock with `i_Wake` = 1 moves to RUN with count = bit 0, step 0001.
  - `i_Stall` is ignored in HALT.
- **Stall**: holds step, count, `len_q`, `exit_q` and state. `o_Instr_Done` is forced 0 while `i_Stall` = 1.
- **Priority at the last T4**: stall > halt > normal wrap.

## Timing
- **Reset values**
  - `o_Cycle_Step` = 0001, `o_Cycle_Count` = 0.
  - `o_Fetch_Cycle` = 1.
  - `o_Last_Cycle` = 0, `o_Instr_Done` = 0, `o_Halted` = 0.
  - `len_q` = 1, `exit_q` = 0.
- Reset asserted mid-instruction returns to FETCH immediately. There is no completion strobe.
- **Latency and throughput**
  - First instruction T1 is 4 clocks after reset release.
  - An N-cycle instruction spans 4·N unstalled clocks.
  - There are no bubbles between instructions.
- **Input sampling**: `i_Early_Exit` and `i_Halt_Req` are sampled only at the T4 edge. `i_Wake` is sampled on any clock in HALT.
- **Output timing**: `o_Last_Cycle` and `o_Instr_Done` are combinational from registered state plus `i_Cycle_Length`/`i_Stall`.

## Structure
- Shared control-unit package holds:
  - FETCH/RUN/HALT state encoding.
  - Step one-hot constants (T1..T4).
  - `MAX_CYCLES` default.
  - The length clamp function.
- One sub-module, `cycle_step_ring`: 4-bit one-hot rotator with hold and reset-to-0001.
- The top level holds the FSM, count shifter, length latch and exit flag.

## Test plan
- **Reset then length 2**: reset release, length 2 → 4 clocks FETCH, then count 01 for 4 steps, count 10 with `o_Last_Cycle` = 1, `o_Instr_Done` at clock 12, count back to 01.
- **Length 1 back-to-back**: three length-1 opcodes → count stays 00000001, `o_Instr_Done` every 4th clock, `o_Last_Cycle` constant 1.
- **Early exit**: length 5, `i_Early_Exit` at T4 of count[1] → count[2] is last, done after 12 clocks of RUN, next count = bit 0.
- **Stall**: `i_Stall` held 3 clocks at T2 of count[1] → step/count frozen, done delayed by exactly 3 clocks, no strobe during stall.
- **Halt and wake**: `i_Halt_Req` on last T4 → `o_Halted` = 1, count 0, step 0001 for 10 clocks; `i_Wake` pulse → RUN count bit 0 next clock.
- **Reset mid-instruction**: assert `i_Reset` at T3 of count[3] of a length-6 opcode → immediate FETCH outputs, no `o_Instr_Done`.
